// File: rtl/obi_arb_2to1.sv
// Two-master to one-slave OBI arbiter in front of the single-port data memory.
// Round-robin selection, address-phase lock until grant, in-order response routing via an ID FIFO.
module obi_arb_2to1 #(
  parameter int MAX_OUT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic                         m0_req_i,
  output logic                         m0_gnt_o,
  output logic                         m0_rvalid_o,
  input  logic [AW-1:0]                m0_addr_i,
  input  logic                         m0_we_i,
  input  logic [DW/8-1:0]              m0_be_i,
  input  logic [DW-1:0]                m0_wdata_i,
  output logic [DW-1:0]                m0_rdata_o,

  input  logic                         m1_req_i,
  output logic                         m1_gnt_o,
  output logic                         m1_rvalid_o,
  input  logic [AW-1:0]                m1_addr_i,
  input  logic                         m1_we_i,
  input  logic [DW/8-1:0]              m1_be_i,
  input  logic [DW-1:0]                m1_wdata_i,
  output logic [DW-1:0]                m1_rdata_o,

  output logic                         port_req_o,
  input  logic                         port_gnt_i,
  input  logic                         port_rvalid_i,
  output logic [AW-1:0]                port_addr_o,
  output logic                         port_we_o,
  output logic [DW/8-1:0]              port_be_o,
  output logic [DW-1:0]                port_wdata_o,
  input  logic [DW-1:0]                port_rdata_i,

  output logic [$clog2(MAX_OUT+1)-1:0] outstanding_o,
  output logic                         err_o
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  // Arbitration state
  logic               last_q;
  logic               lock_q;
  logic               lock_sel_q;
  logic               err_q;

  // ID FIFO: one bit per granted-but-unanswered transaction, the issuing master
  logic [MAX_OUT-1:0] fifo_q;
  logic [PW-1:0]      wptr_q;
  logic [PW-1:0]      rptr_q;
  logic [CW-1:0]      count_q;

  logic               sel;
  logic               sel_req;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(MAX_OUT - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // A pending address phase pins the selection; otherwise a tie goes to the master not served last.
  always_comb begin
    sel = ~last_q;
    if (lock_q) begin
      sel = lock_sel_q;
    end else if (m0_req_i && !m1_req_i) begin
      sel = 1'b0;
    end else if (m1_req_i && !m0_req_i) begin
      sel = 1'b1;
    end
  end

  assign sel_req = sel ? m1_req_i : m0_req_i;
  assign full    = (count_q == CW'(MAX_OUT));
  assign empty   = (count_q == '0);
  assign head    = fifo_q[rptr_q];

  // Full is judged on the registered count, so a same-cycle pop never unblocks a request.
  assign port_req_o   = sel_req & ~full;
  assign port_addr_o  = sel ? m1_addr_i  : m0_addr_i;
  assign port_we_o    = sel ? m1_we_i    : m0_we_i;
  assign port_be_o    = sel ? m1_be_i    : m0_be_i;
  assign port_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

  assign push = port_req_o & port_gnt_i;
  assign pop  = port_rvalid_i & ~empty;

  assign m0_gnt_o    = push & ~sel;
  assign m1_gnt_o    = push & sel;
  assign m0_rvalid_o = pop & ~head;
  assign m1_rvalid_o = pop & head;
  assign m0_rdata_o  = port_rdata_i;
  assign m1_rdata_o  = port_rdata_i;

  assign outstanding_o = count_q;
  assign err_o         = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 1'b1;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
    end else if (push) begin
      last_q <= sel;
      lock_q <= 1'b0;
    end else if (port_req_o) begin
      lock_q     <= 1'b1;
      lock_sel_q <= sel;
    end else if (lock_q && !sel_req) begin
      lock_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= sel;
        wptr_q         <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Sticky: spurious response, or a locked requester withdrawing before its grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((port_rvalid_i && empty) || (lock_q && !sel_req)) begin
      err_q <= 1'b1;
    end
  end

endmodule
